mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multi-cycle multiply/divide unit for the EX stage, beside the combinational ALU.
- Serves mult, multu, div, divu, mthi and mtlo; owns the architectural HI/LO registers.
- Exposes a busy flag. The pipeline controller stalls any HI/LO-touching instruction in ID while busy or start is high.
- mfhi/mflo read the HI/LO outputs directly.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- A  input  32  rs operand (dividend or multiplicand; source value for mthi/mtlo).
- B  input  32  rt operand (divisor or multiplier).
- op  input  4  operation select, encoding below.
- start  input  1  one-cycle launch strobe from EX.
- busy  output  1  high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Shared op encoding: md_none=0, md_mult=1, md_multu=2, md_div=3, md_divu=4, md_mthi=5, md_mtlo=6. Values 7..15 are treated as md_none.
- Reset: busy=0, HI=0, LO=0, internal counter=0, latched results=0. Reset takes priority over every other input.
- Reset mid-operation: the operation is aborted, HI/LO end at 0, and busy is low on the next cycle.
- Launch is accepted only when start=1, busy=0 and op is 1..4 at a rising edge. At that edge:
  - A and B are latched.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
- busy is exactly (counter != 0). It rises the cycle after launch and stays high N cycles.
- Each edge with counter != 0 decrements the counter. On the 1->0 edge, HI/LO are written with the latched result.
- New HI/LO become visible in the same cycle busy falls.
- Back-to-back: a launch is accepted in the first cycle busy is low.
- mult: signed 32x32 -> 64-bit product; HI=[63:32], LO=[31:0].
- multu: the same as mult with unsigned operands.
- div: signed division.
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned division; LO = quotient, HI = remainder.
- Divide by zero (B=0, div or divu): runs the full DIV_CYCLES with busy high; HI and LO are left unchanged.
- mthi/mtlo with start=1 and busy=0: on that edge HI<=A (or LO<=A). busy stays 0; the write is visible next cycle.
- start=1 while busy=1 (any op) is ignored: no state change and the in-flight operation is unaffected.
- start=1 with md_none is a no-op.
- start=0: op, A and B are don't-care.
- Operands are sampled only at launch. Changes to A/B during busy have no effect.
- Timing: outputs are register-driven. The 32x32 multiply may be one combinational product at launch, or registered in stages, provided the cycle contract above holds exactly.

Decomposition:
- Shared macro/package file holds:
  - the md_* op codes;
  - MDU default cycle counts;
  - 64-bit/32-bit width constants, next to the existing ALU op codes.
- Optional sub-module: mdu_div_core, a 32-bit signed/unsigned quotient/remainder unit with sign fix-up. mdu keeps the FSM, counter and HI/LO.
- FSM: IDLE (counter=0) -> RUN (counter>0) -> IDLE on commit. The counter alone encodes the state.

Test Plan:
1. Reset for 2 cycles, then idle -> busy=0, HI=0, LO=0.
2. mult A=0xFFFFFFFE (-2), B=0x00000003 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with multu -> HI=0x00000002, LO=0xFFFFFFFA.
3. div A=0xFFFFFFF9 (-7), B=0x00000002 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
   - divu A=7, B=2 -> LO=3, HI=1.
   - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Preload HI=0x1234 and LO=0x5678 via mthi/mtlo (each visible the next cycle, busy stays 0), then divu by B=0 -> busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
5. Launch mult 3*4; at busy cycle 2, pulse start with mtlo A=0xDEAD and with div -> both ignored; result HI=0, LO=12. A launch in the first cycle busy is low is accepted.
6. Launch div, assert reset at busy cycle 4 -> next cycle busy=0, HI=0, LO=0. No later commit occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, cycle counts, widths.
package mdu_pkg;

  localparam int md_w  = 32;
  localparam int md_dw = 64;

  localparam int md_mult_cycles_def = 5;
  localparam int md_div_cycles_def  = 10;

  typedef enum logic [3:0] {
    md_none  = 4'd0,
    md_mult  = 4'd1,
    md_multu = 4'd2,
    md_div   = 4'd3,
    md_divu  = 4'd4,
    md_mthi  = 4'd5,
    md_mtlo  = 4'd6
  } md_op_e;

  function automatic logic [md_dw-1:0] ext64(input logic [md_w-1:0] v, input logic sgn);
    return {{md_w{sgn & v[md_w-1]}}, v};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit quotient/remainder with signed fix-up (truncating division).
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic [md_w-1:0] a,
  input  logic [md_w-1:0] b,
  input  logic            is_signed,
  output logic [md_w-1:0] q,
  output logic [md_w-1:0] r
);

  logic            neg_a, neg_b;
  logic [md_w-1:0] mag_a, mag_b, uq, ur;

  always_comb begin
    neg_a = is_signed & a[md_w-1];
    neg_b = is_signed & b[md_w-1];
    mag_a = neg_a ? (~a + 1'b1) : a;
    mag_b = neg_b ? (~b + 1'b1) : b;
    uq    = '0;
    ur    = '0;
    if (mag_b != '0) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    // Quotient sign from operand signs, remainder follows the dividend.
    q = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
    r = neg_a ? (~ur + 1'b1) : ur;
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; the counter alone encodes idle vs run.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = md_mult_cycles_def,
  parameter int DIV_CYCLES  = md_div_cycles_def
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [md_w-1:0] A,
  input  logic [md_w-1:0] B,
  input  logic [3:0]      op,
  input  logic            start,
  output logic            busy,
  output logic [md_w-1:0] HI,
  output logic [md_w-1:0] LO
);

  typedef enum logic {st_idle, st_run} state_e;

  localparam logic [3:0] mult_n = 4'(MULT_CYCLES);
  localparam logic [3:0] div_n  = 4'(DIV_CYCLES);

  state_e           state;
  logic [3:0]       cnt, cnt_n;
  logic [md_dw-1:0] res, res_n;
  logic             wr, wr_n;
  logic [md_w-1:0]  hi_n, lo_n;
  logic [md_dw-1:0] prod;
  logic [md_w-1:0]  dq, dr;

  assign state = (cnt != '0) ? st_run : st_idle;
  assign busy  = (cnt != '0);

  assign prod = ext64(A, op == md_mult) * ext64(B, op == md_mult);

  mdu_div_core u_div (
    .a        (A),
    .b        (B),
    .is_signed(op == md_div),
    .q        (dq),
    .r        (dr)
  );

  // The result is computed from the operands at launch and held until commit,
  // which is equivalent to latching A/B and computing at the end.
  always_comb begin
    cnt_n = cnt;
    res_n = res;
    wr_n  = wr;
    hi_n  = HI;
    lo_n  = LO;
    case (state)
      st_idle: begin
        if (start) begin
          case (op)
            md_mult, md_multu: begin
              cnt_n = mult_n;
              res_n = prod;
              wr_n  = 1'b1;
            end
            md_div, md_divu: begin
              cnt_n = div_n;
              res_n = {dr, dq};
              wr_n  = (B != '0);
            end
            md_mthi: hi_n = A;
            md_mtlo: lo_n = A;
            default: ;
          endcase
        end
      end
      st_run: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1 && wr) begin
          hi_n = res[md_dw-1:md_w];
          lo_n = res[md_w-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      res <= '0;
      wr  <= 1'b0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      cnt <= cnt_n;
      res <= res_n;
      wr  <= wr_n;
      HI  <= hi_n;
      LO  <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: timestamp-based reference model plus directed and random stimulus.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  op = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  localparam int NM = 5;
  localparam int ND = 10;

  mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .op   (op),
    .start(start),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an operation launched at edge L commits at edge L+N.
  int          cyc = 0;
  bit          m_valid = 0;
  bit          m_pending = 0;
  int          m_done_at = 0;
  bit          m_wr = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

  always @(posedge clk) begin
    longint          sa, sb, q, r;
    longint unsigned up;
    m_valid = 1;
    if (reset) begin
      m_pending = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_pending) begin
      if (cyc == m_done_at) begin
        m_pending = 0;
        if (m_wr) begin
          m_hi = m_rhi;
          m_lo = m_rlo;
        end
      end
    end else if (start) begin
      case (op)
        4'd1, 4'd2: begin
          if (op == 4'd1) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            up = longint'(sa * sb);
          end else begin
            up = {32'b0, A} * {32'b0, B};
          end
          m_rhi = up[63:32];
          m_rlo = up[31:0];
          m_wr = 1;
          m_pending = 1;
          m_done_at = cyc + NM;
        end
        4'd3, 4'd4: begin
          if (op == 4'd3) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
          end else begin
            sa = longint'({32'b0, A});
            sb = longint'({32'b0, B});
          end
          m_wr = (B != 0);
          if (m_wr) begin
            q = sa / sb;
            r = sa % sb;
            m_rlo = q[31:0];
            m_rhi = r[31:0];
          end
          m_pending = 1;
          m_done_at = cyc + ND;
        end
        4'd5: m_hi = A;
        4'd6: m_lo = A;
        default: ;
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", {31'b0, busy}, {31'b0, m_pending});
      chk("model_hi", HI, m_hi);
      chk("model_lo", LO, m_lo);
    end
  end

  task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    op = 4'd0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'(($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);

    launch(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    launch(4'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    launch(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    launch(4'd4, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);
    launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'h0);

    launch(4'd5, 32'h1234, 32'h0);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    launch(4'd6, 32'h5678, 32'h0);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_lo", LO, 32'h5678);
    launch(4'd4, 32'd99, 32'd0);
    wait_idle(n);
    chk("divz_cycles", 32'(n), 32'd10);
    chk("divz_hi", HI, 32'h1234);
    chk("divz_lo", LO, 32'h5678);

    launch(4'd1, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; op = 4'd6; A = 32'hDEAD;
    @(negedge clk);
    op = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    wait_idle(n);
    chk("ignore_cycles", 32'(n + 3), 32'd5);
    chk("ignore_hi", HI, 32'h0);
    chk("ignore_lo", LO, 32'd12);
    launch(4'd4, 32'd20, 32'd6);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_lo", LO, 32'd3);
    chk("b2b_hi", HI, 32'd2);

    launch(4'd3, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'h0);
    chk("rst_mid_lo", LO, 32'h0);
    repeat (12) @(negedge clk);
    chk("rst_nocommit_lo", LO, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 2) == 0);
      op = 4'($urandom_range(0, 15));
      A = pick();
      B = ($urandom_range(0, 9) == 0) ? 32'h0 : pick();
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
